// File: rtl/coremesh_arb_pkg.sv
// coremesh_arb_pkg: shared state encoding and default sizes for the coremesh Wishbone arbiter
package coremesh_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_ADR_WIDTH      = 32;
    localparam int DEF_DAT_WIDTH      = 32;
    localparam int DEF_TGC_WIDTH      = 4;
    localparam int DEF_N_INITIATORS   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int TO_CNT_WIDTH       = 16;

endpackage

// File: rtl/coremesh_rr_pick.sv
// coremesh_rr_pick: rotating-priority pick, first request after the last-served index wins
module coremesh_rr_pick #(
    parameter int N_INITIATORS = 4,
    localparam int LW = $clog2(N_INITIATORS)
) (
    input  logic [N_INITIATORS-1:0] req,
    input  logic [LW-1:0]           last,
    output logic [N_INITIATORS-1:0] pick,
    output logic                    valid
);

    logic [LW-1:0] idx;

    // scan last+1, last+2, ... wrapping, and keep the first hit
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_INITIATORS; i++) begin
            idx = LW'((int'(last) + i) % N_INITIATORS);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coremesh_wb_rr_arbiter.sv
// coremesh_wb_rr_arbiter: round-robin N-to-1 Wishbone arbiter; COREMESH_ARB_TIMEOUT_EN adds a BUSY watchdog
module coremesh_wb_rr_arbiter
    import coremesh_arb_pkg::*;
#(
    parameter int ADR_WIDTH      = DEF_ADR_WIDTH,
    parameter int DAT_WIDTH      = DEF_DAT_WIDTH,
    parameter int TGC_WIDTH      = DEF_TGC_WIDTH,
    parameter int N_INITIATORS   = DEF_N_INITIATORS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [N_INITIATORS*ADR_WIDTH-1:0] i_adr,
    input  logic [N_INITIATORS*DAT_WIDTH-1:0] i_dat_w,
    output logic [DAT_WIDTH-1:0]              i_dat_r,
    input  logic [N_INITIATORS-1:0]           i_cyc,
    input  logic [N_INITIATORS-1:0]           i_stb,
    input  logic [N_INITIATORS-1:0]           i_we,
    input  logic [N_INITIATORS*DAT_WIDTH/8-1:0] i_sel,
    input  logic [N_INITIATORS*TGC_WIDTH-1:0] i_tgc,
    output logic [N_INITIATORS-1:0]           i_ack,
    output logic [N_INITIATORS-1:0]           i_err,
    output logic [ADR_WIDTH-1:0]              t_adr,
    output logic [DAT_WIDTH-1:0]              t_dat_w,
    input  logic [DAT_WIDTH-1:0]              t_dat_r,
    output logic                              t_cyc,
    output logic                              t_stb,
    output logic                              t_we,
    output logic [DAT_WIDTH/8-1:0]            t_sel,
    output logic [TGC_WIDTH-1:0]              t_tgc,
    input  logic                              t_ack,
    input  logic                              t_err,
    output logic [N_INITIATORS-1:0]           grant_o
);

    localparam int SW = DAT_WIDTH / 8;
    localparam int LW = $clog2(N_INITIATORS);

    if (N_INITIATORS < 2 || N_INITIATORS > 8)
        $error("N_INITIATORS must be 2..8");
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2 ** TO_CNT_WIDTH)
        $error("TIMEOUT_CYCLES does not fit the watchdog counter");

    arb_state_t state, state_nx;
    logic [N_INITIATORS-1:0] grant, grant_nx, req, pick;
    logic [LW-1:0] owner, owner_nx, last, last_nx, pick_idx;
    logic pick_valid, busy, done, timeout;

    logic [ADR_WIDTH-1:0] adr_a [N_INITIATORS];
    logic [DAT_WIDTH-1:0] dat_a [N_INITIATORS];
    logic [SW-1:0]        sel_a [N_INITIATORS];
    logic [TGC_WIDTH-1:0] tgc_a [N_INITIATORS];

    for (genvar k = 0; k < N_INITIATORS; k++) begin : g_unpack
        assign adr_a[k] = i_adr[k*ADR_WIDTH +: ADR_WIDTH];
        assign dat_a[k] = i_dat_w[k*DAT_WIDTH +: DAT_WIDTH];
        assign sel_a[k] = i_sel[k*SW +: SW];
        assign tgc_a[k] = i_tgc[k*TGC_WIDTH +: TGC_WIDTH];
    end

    assign req  = i_cyc & i_stb;
    assign busy = state == ARB_BUSY;

    coremesh_rr_pick #(.N_INITIATORS(N_INITIATORS)) u_pick (
        .req   (req),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    // one-hot pick to owner index for the data-path muxes
    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_INITIATORS; k++)
            if (pick[k]) pick_idx = LW'(k);
    end

`ifdef COREMESH_ARB_TIMEOUT_EN
    logic [TO_CNT_WIDTH-1:0] cnt;

    // watchdog: zero while idle, counts every cycle the owner waits in BUSY
    always_ff @(posedge clock) begin
        cnt <= (reset || !busy) ? '0 : cnt + 1'b1;
    end

    assign timeout = busy && cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES);
`else
    assign timeout = 1'b0;
`endif

    // a transaction ends on completion, abort, or watchdog expiry
    assign done = busy && (t_ack || t_err || !i_cyc[owner] || timeout);

    // next owner: grant from IDLE, release to IDLE when done
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        owner_nx = owner;
        last_nx  = last;
        if (!busy && pick_valid) begin
            state_nx = ARB_BUSY;
            grant_nx = pick;
            owner_nx = pick_idx;
        end else if (done) begin
            state_nx = ARB_IDLE;
            grant_nx = '0;
            last_nx  = owner;
        end
    end

    // state register; reset leaves initiator 0 first in line
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARB_IDLE;
            grant <= '0;
            owner <= '0;
            last  <= LW'(N_INITIATORS - 1);
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            owner <= owner_nx;
            last  <= last_nx;
        end
    end

    assign t_adr   = adr_a[owner];
    assign t_dat_w = dat_a[owner];
    assign t_sel   = sel_a[owner];
    assign t_tgc   = tgc_a[owner];
    assign t_we    = i_we[owner];
    assign t_cyc   = busy && i_cyc[owner] && !timeout;
    assign t_stb   = busy && i_stb[owner] && !timeout;
    assign i_ack   = (busy && t_ack && !timeout) ? grant : '0;
    assign i_err   = (busy && (t_err || timeout)) ? grant : '0;
    assign i_dat_r = t_dat_r;
    assign grant_o = grant;

endmodule

// File: tb/tb_coremesh_wb_rr_arbiter.sv
// tb_coremesh_wb_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model
module tb_coremesh_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] i_adr;
    logic [N*DW-1:0] i_dat_w;
    logic [DW-1:0]   i_dat_r;
    logic [N-1:0]    i_cyc, i_stb, i_we, i_ack, i_err, grant_o;
    logic [N*DW/8-1:0] i_sel;
    logic [N*TW-1:0] i_tgc;
    logic [AW-1:0]   t_adr;
    logic [DW-1:0]   t_dat_w, t_dat_r;
    logic            t_cyc, t_stb, t_we, t_ack, t_err;
    logic [DW/8-1:0] t_sel;
    logic [TW-1:0]   t_tgc;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    coremesh_wb_rr_arbiter #(
        .ADR_WIDTH(AW), .DAT_WIDTH(DW), .TGC_WIDTH(TW),
        .N_INITIATORS(N), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_tgc(i_tgc),
        .i_ack(i_ack), .i_err(i_err),
        .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_tgc(t_tgc),
        .t_ack(t_ack), .t_err(t_err), .grant_o(grant_o)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        i_cyc = '0; i_stb = '0; i_we = '0; i_adr = '0; i_dat_w = '0;
        i_sel = '0; i_tgc = '0; t_ack = 1'b0; t_err = 1'b0; t_dat_r = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clock);
        checks++; if (t_cyc !== 1'b0) begin failures++; $display("FAIL reset_t_cyc got=%b exp=0", t_cyc); end
        checks++; if (t_stb !== 1'b0) begin failures++; $display("FAIL reset_t_stb got=%b exp=0", t_stb); end
        checks++; if (i_ack !== 4'b0) begin failures++; $display("FAIL reset_i_ack got=%b exp=0000", i_ack); end
        checks++; if (i_err !== 4'b0) begin failures++; $display("FAIL reset_i_err got=%b exp=0000", i_err); end
        checks++; if (grant_o !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
    endtask

    task automatic test_single;
        do_reset();
        i_cyc = 4'b0010; i_stb = 4'b0010;
        i_adr[63:32] = 32'h8000_0010; i_tgc[7:4] = 4'h5; i_sel[7:4] = 4'hF;
        @(negedge clock);
        checks++; if (t_cyc !== 1'b0 || grant_o !== 4'b0) begin failures++; $display("FAIL single_latency t_cyc=%b grant=%b exp 0/0000", t_cyc, grant_o); end
        step();
        @(negedge clock);
        checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", grant_o); end
        checks++; if (t_cyc !== 1'b1 || t_stb !== 1'b1) begin failures++; $display("FAIL single_t_cyc got=%b%b exp=11", t_cyc, t_stb); end
        checks++; if (t_adr !== 32'h8000_0010) begin failures++; $display("FAIL single_t_adr got=%h exp=80000010", t_adr); end
        checks++; if (t_tgc !== 4'h5 || t_sel !== 4'hF) begin failures++; $display("FAIL single_tgc_sel got=%h/%h exp=5/f", t_tgc, t_sel); end
        checks++; if (i_ack !== 4'b0) begin failures++; $display("FAIL single_early_ack got=%b exp=0000", i_ack); end
        step();
        t_ack = 1'b1; t_dat_r = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++; if (i_ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", i_ack); end
        checks++; if (i_dat_r !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_dat_r got=%h exp=deadbeef", i_dat_r); end
        checks++; if (i_err !== 4'b0) begin failures++; $display("FAIL single_err got=%b exp=0000", i_err); end
        step();
        idle_inputs();
        @(negedge clock);
        checks++; if (grant_o !== 4'b0 || i_ack !== 4'b0 || t_cyc !== 1'b0) begin failures++; $display("FAIL single_release grant=%b ack=%b t_cyc=%b exp 0000/0000/0", grant_o, i_ack, t_cyc); end
    endtask

    task automatic test_all_four;
        int order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] e;
        do_reset();
        i_cyc = 4'hF; i_stb = 4'hF;
        for (int k = 0; k < N; k++) begin
            i_tgc[k*TW +: TW] = TW'(k + 8);
            i_adr[k*AW +: AW] = 32'h1000_0000 + 32'(k);
        end
        for (int j = 0; j < 5; j++) begin
            e = 4'(1 << order[j]);
            @(negedge clock);
            checks++; if (grant_o !== 4'b0 || t_cyc !== 1'b0) begin failures++; $display("FAIL all4_gap%0d grant=%b t_cyc=%b exp 0000/0", j, grant_o, t_cyc); end
            step();
            t_ack = 1'b1;
            @(negedge clock);
            checks++; if (grant_o !== e) begin failures++; $display("FAIL all4_grant%0d got=%b exp=%b", j, grant_o, e); end
            checks++; if (t_tgc !== TW'(order[j] + 8)) begin failures++; $display("FAIL all4_tgc%0d got=%h exp=%h", j, t_tgc, order[j] + 8); end
            checks++; if (i_ack !== e) begin failures++; $display("FAIL all4_ack%0d got=%b exp=%b", j, i_ack, e); end
            step();
            t_ack = 1'b0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_alternate;
        int order[4] = '{2, 0, 2, 0};
        logic [3:0] e;
        do_reset();
        i_cyc = 4'b0001; i_stb = 4'b0001;
        step();
        t_ack = 1'b1;
        @(negedge clock);
        checks++; if (grant_o !== 4'b0001) begin failures++; $display("FAIL alt_prime got=%b exp=0001", grant_o); end
        step();
        t_ack = 1'b0;
        i_cyc = 4'b0101; i_stb = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            e = 4'(1 << order[j]);
            @(negedge clock);
            checks++; if (grant_o !== 4'b0) begin failures++; $display("FAIL alt_gap%0d got=%b exp=0000", j, grant_o); end
            step();
            t_ack = 1'b1;
            @(negedge clock);
            checks++; if (grant_o !== e || i_ack !== e) begin failures++; $display("FAIL alt_grant%0d grant=%b ack=%b exp=%b", j, grant_o, i_ack, e); end
            step();
            t_ack = 1'b0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_abort;
        do_reset();
        i_cyc = 4'b1000; i_stb = 4'b1000; i_adr[127:96] = 32'hABCD_0000;
        step();
        @(negedge clock);
        checks++; if (grant_o !== 4'b1000 || t_cyc !== 1'b1) begin failures++; $display("FAIL abort_grant grant=%b t_cyc=%b exp 1000/1", grant_o, t_cyc); end
        step();
        i_cyc = 4'b0001; i_stb = 4'b0001;
        @(negedge clock);
        checks++; if (i_ack !== 4'b0 || i_err !== 4'b0) begin failures++; $display("FAIL abort_no_ack ack=%b err=%b exp 0000/0000", i_ack, i_err); end
        checks++; if (t_cyc !== 1'b0) begin failures++; $display("FAIL abort_t_cyc got=%b exp=0", t_cyc); end
        step();
        @(negedge clock);
        checks++; if (grant_o !== 4'b0 || t_cyc !== 1'b0) begin failures++; $display("FAIL abort_idle grant=%b t_cyc=%b exp 0000/0", grant_o, t_cyc); end
        step();
        t_ack = 1'b1;
        @(negedge clock);
        checks++; if (grant_o !== 4'b0001 || i_ack !== 4'b0001) begin failures++; $display("FAIL abort_next grant=%b ack=%b exp 0001", grant_o, i_ack); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid;
        do_reset();
        i_cyc = 4'b0010; i_stb = 4'b0010;
        step();
        t_ack = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (grant_o !== 4'b0010) begin failures++; $display("FAIL rstmid_pre got=%b exp=0010", grant_o); end
        step();
        reset = 1'b0;
        i_cyc = 4'b0011; i_stb = 4'b0011;
        @(negedge clock);
        checks++; if (t_cyc !== 1'b0 || i_ack !== 4'b0 || grant_o !== 4'b0) begin failures++; $display("FAIL rstmid_post t_cyc=%b ack=%b grant=%b exp 0/0000/0000", t_cyc, i_ack, grant_o); end
        step();
        t_ack = 1'b0;
        @(negedge clock);
        checks++; if (grant_o !== 4'b0001 || t_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_first grant=%b t_cyc=%b exp 0001/1", grant_o, t_cyc); end
        step();
        t_ack = 1'b1;
        step();
        idle_inputs();
        step();
    endtask

`ifdef COREMESH_ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        i_cyc = 4'b0100; i_stb = 4'b0100;
        step();
        for (int b = 0; b <= TO; b++) begin
            @(negedge clock);
            if (b < TO) begin
                checks++; if (i_err !== 4'b0 || t_cyc !== 1'b1) begin failures++; $display("FAIL to_wait%0d err=%b t_cyc=%b exp 0000/1", b, i_err, t_cyc); end
            end else begin
                checks++; if (i_err !== 4'b0100 || t_cyc !== 1'b0 || i_ack !== 4'b0) begin failures++; $display("FAIL to_fire err=%b t_cyc=%b ack=%b exp 0100/0/0000", i_err, t_cyc, i_ack); end
            end
            step();
        end
        i_cyc = 4'b0; i_stb = 4'b0; t_ack = 1'b1;
        @(negedge clock);
        checks++; if (i_ack !== 4'b0 || grant_o !== 4'b0) begin failures++; $display("FAIL to_late_ack ack=%b grant=%b exp 0000/0000", i_ack, grant_o); end
        step();
        idle_inputs();
        step();
    endtask
`endif

    task automatic test_random;
        logic [N-1:0] pend;
        logic [AW-1:0] madr[N];
        logic [TW-1:0] mtgc[N];
        logic [3:0] eg, ea, ee;
        bit mb, to, ec;
        int mo, ml, mw, kk;
        do_reset();
        pend = '0; mb = 0; mo = 0; ml = N - 1; mw = 0;
        for (int k = 0; k < N; k++) begin madr[k] = '0; mtgc[k] = '0; end
        repeat (400) begin
            for (int k = 0; k < N; k++)
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k] = 1'b1;
                    madr[k] = $urandom;
                    mtgc[k] = TW'($urandom);
                end
            if (mb && $urandom_range(9) == 0) pend[mo] = 1'b0;
            i_cyc = pend; i_stb = pend;
            for (int k = 0; k < N; k++) begin
                i_adr[k*AW +: AW] = madr[k];
                i_tgc[k*TW +: TW] = mtgc[k];
            end
            t_ack = ($urandom_range(2) == 0);
            t_err = !t_ack && ($urandom_range(7) == 0);
            to = 0;
`ifdef COREMESH_ARB_TIMEOUT_EN
            to = mb && mw == TO;
`endif
            eg = mb ? 4'(1 << mo) : 4'b0;
            ec = mb && pend[mo] && !to;
            ea = (mb && t_ack && !to) ? eg : 4'b0;
            ee = (mb && (t_err || to)) ? eg : 4'b0;
            @(negedge clock);
            checks++; if (grant_o !== eg) begin failures++; $display("FAIL rnd_grant got=%b exp=%b", grant_o, eg); end
            checks++; if (t_cyc !== ec) begin failures++; $display("FAIL rnd_t_cyc got=%b exp=%b", t_cyc, ec); end
            checks++; if (i_ack !== ea) begin failures++; $display("FAIL rnd_ack got=%b exp=%b", i_ack, ea); end
            checks++; if (i_err !== ee) begin failures++; $display("FAIL rnd_err got=%b exp=%b", i_err, ee); end
            if (ec) begin
                checks++; if (t_adr !== madr[mo] || t_tgc !== mtgc[mo]) begin failures++; $display("FAIL rnd_mux adr=%h tgc=%h exp %h/%h", t_adr, t_tgc, madr[mo], mtgc[mo]); end
            end
            if (!mb) begin
                for (int s = 1; s <= N; s++) begin
                    kk = (ml + s) % N;
                    if (!mb && pend[kk]) begin mb = 1; mo = kk; mw = 0; end
                end
            end else if (to || t_ack || t_err || !pend[mo]) begin
                mb = 0; ml = mo; pend[mo] = 1'b0;
            end else begin
                mw++;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_abort();
        test_reset_mid();
`ifdef COREMESH_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coremesh_wb_rr_arbiter.md
Name: coremesh_wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that lets N_INITIATORS cluster cores share one tagged Wishbone target (the cluster SRAM/bus port).
- Sits between the core initiator ports and a single target port, in place of a full NxN interconnect when only one target exists.
- Grant is held for the whole transaction, from stb through ack/err, so exactly one initiator owns the target at a time.
- Fairness: the last-served initiator gets lowest priority on the next arbitration.

Parameters:
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; byte-select width is DAT_WIDTH/8.
- TGC_WIDTH, 4, cycle-tag width.
- N_INITIATORS, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_adr  in  N_INITIATORS*ADR_WIDTH  packed initiator addresses; initiator k is slice k
- i_dat_w  in  N_INITIATORS*DAT_WIDTH  packed write data
- i_dat_r  out  DAT_WIDTH  read data, broadcast to all initiators
- i_cyc  in  N_INITIATORS  cycle valid
- i_stb  in  N_INITIATORS  strobe
- i_we  in  N_INITIATORS  write enable
- i_sel  in  N_INITIATORS*DAT_WIDTH/8  byte selects
- i_tgc  in  N_INITIATORS*TGC_WIDTH  cycle tags
- i_ack  out  N_INITIATORS  per-initiator ack
- i_err  out  N_INITIATORS  per-initiator error
- t_adr  out  ADR_WIDTH  target address
- t_dat_w  out  DAT_WIDTH  target write data
- t_dat_r  in  DAT_WIDTH  target read data
- t_cyc  out  1  target cycle
- t_stb  out  1  target strobe
- t_we  out  1  target write enable
- t_sel  out  DAT_WIDTH/8  target byte selects
- t_tgc  out  TGC_WIDTH  target cycle tag
- t_ack  in  1  target ack
- t_err  in  1  target error
- grant_o  out  N_INITIATORS  one-hot current owner (debug/perf)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- State at reset: state=IDLE, grant=0, last=N_INITIATORS-1 (initiator 0 has top priority first).
- Outputs at reset: t_cyc=0, t_stb=0, i_ack=0, i_err=0, grant_o=0.
- Request: req[k] = i_cyc[k] & i_stb[k].
- IDLE state:
  - If any req is set, pick the first set req scanning last+1, last+2, … modulo N_INITIATORS.
  - Register the pick as one-hot grant and go to BUSY.
  - Arbitration latency is one cycle: t_cyc/t_stb first assert the cycle after the request is seen.
- BUSY state:
  - t_adr, t_dat_w, t_we, t_sel and t_tgc are combinationally muxed from the granted initiator.
  - t_cyc = i_cyc[g]; t_stb = i_stb[g].
  - i_ack[g] = t_ack and i_err[g] = t_err, combinationally. All non-granted ack/err bits are 0.
  - i_dat_r = t_dat_r at all times.
- End of transaction: on t_ack|t_err, set last=g, clear grant, and return to IDLE at the next edge.
  - The next grant can issue in that IDLE cycle, so there is one dead cycle between back-to-back transactions.
- Abort: if i_cyc[g] drops while in BUSY without ack/err, return to IDLE.
  - last is still updated.
  - No ack/err is generated.
- Simultaneous events:
  - ack and abort in the same cycle: treat as a completion.
  - New requests arriving while BUSY are held off: no ack is returned to them and their stb stays asserted (WB classic).
- No-request case: t_cyc=t_stb=0 whenever state=IDLE.
- Reset mid-transaction: the bus is dropped immediately at the edge (t_cyc=0) and any pending ack is discarded.
- Owner change: grant changes only on transitions into or out of IDLE, never mid-transaction.

Optional Feature:
- Macro: COREMESH_ARB_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter clears on grant and increments each BUSY cycle without ack/err.
  - When the count reaches TIMEOUT_CYCLES, drive i_err[g]=1 for one cycle and t_cyc=t_stb=0, then go to IDLE with last=g.
  - A late t_ack after timeout is ignored.
- Disabled: no counter logic; BUSY waits indefinitely.

Decomposition:
- Shared package coremesh_arb_pkg holds:
  - state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1);
  - default width constants;
  - the timeout counter width.
- One sub-module is natural: coremesh_rr_pick.
  - Combinational priority-rotate: inputs req and last, outputs one-hot pick and valid.
  - Reusable by future multi-target interconnects.

Test Plan:
- Single requester: core 1 reads adr 0x8000_0010, target acks on the 2nd BUSY cycle with 0xDEADBEEF.
  - Required: i_ack=4'b0010 for one cycle; i_dat_r=0xDEADBEEF; grant_o returns to 0.
- All four request together after reset.
  - Required: grants in order 0,1,2,3,0 with one IDLE cycle between each.
  - Required: t_tgc matches each owner's tag.
- Cores 0 and 2 request continuously, and core 0 was just served.
  - Required: core 2 is granted next; strict alternation 2,0,2,0.
- Core 3 drops cyc mid-BUSY with no ack.
  - Required: arbiter goes IDLE next cycle; no i_ack/i_err; core 0 (next in rotation) is then granted.
- Reset asserted during BUSY with t_ack arriving the same cycle.
  - Required: after the edge, t_cyc=0, i_ack=0, grant_o=0; the first post-reset grant goes to core 0.
- With COREMESH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: target never acks core 2.
  - Required: i_err=4'b0100 exactly 8 BUSY cycles after grant; then IDLE.
  - Required: a later t_ack produces no i_ack.
